// File: rtl/sysray_pkg.sv
// Shared types and helpers for the sysray controller and its bench.
package sysray_pkg;

    localparam int unsigned DefaultN = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoadW  = 2'd1,
        StStream = 2'd2,
        StDone   = 2'd3
    } sysray_state_e;

    // Cycles spent in STREAM: last result of the last column leaves the array bottom.
    function automatic int unsigned stream_len(input int unsigned m, input int unsigned n,
                                               input int unsigned pe_lat);
        return m + 2 * n - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/sysray_skew.sv
// Combinational skew generator: per-row input valids/addresses and per-column result
// valids as a function of the stream counter t and the tile row count M.
module sysray_skew
    import sysray_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PE_LAT = 1,
    localparam int unsigned CntW  = ADDR_W + 2
) (
    input  logic                  en_i,
    input  logic [CntW-1:0]       t_i,
    input  logic [ADDR_W-1:0]     m_i,
    output logic [N-1:0]          x_valid_o,
    output logic [N*ADDR_W-1:0]   x_addr_o,
    output logic [N-1:0]          y_valid_o
);

    logic [31:0] t_ext;
    logic [31:0] m_ext;

    // Row i is fed t-i at stream step t; column j drains N-1+PE_LAT+j steps later.
    always_comb begin
        x_valid_o = '0;
        x_addr_o  = '0;
        y_valid_o = '0;
        t_ext     = 32'(t_i);
        m_ext     = 32'(m_i);
        for (int unsigned i = 0; i < N; i++) begin
            // Lower bound checked first so t-i is only formed when t >= i.
            if (en_i && t_ext >= i && t_ext < m_ext + i) begin
                x_valid_o[i]                 = 1'b1;
                x_addr_o[i*ADDR_W +: ADDR_W] = ADDR_W'(t_ext - i);
            end
            if (en_i && t_ext >= N - 1 + PE_LAT + i && t_ext < m_ext + N - 1 + PE_LAT + i) begin
                y_valid_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sysray_ctrl.sv
// Sequencer for the weight-stationary sysray array: LOAD_W then STREAM per tile.
// Optional busy-cycle counter enabled by defining SYSRAY_CTRL_PERF_EN.
module sysray_ctrl
    import sysray_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  keep_w_i,
    input  logic [ADDR_W-1:0]     num_rows_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  w_rd_en_o,
    output logic [$clog2(N)-1:0]  w_rd_addr_o,
    output logic [N-1:0]          w_valid_o,
    output logic [N-1:0]          x_rd_en_o,
    output logic [N*ADDR_W-1:0]   x_rd_addr_o,
    output logic [N-1:0]          x_valid_o,
    output logic [N-1:0]          y_valid_o
`ifdef SYSRAY_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles_o
`endif
);

    localparam int unsigned CntW   = ADDR_W + 2;
    localparam int unsigned WAddrW = $clog2(N);

    sysray_state_e     state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] m_q, m_d;
    logic              w_loaded_q, w_loaded_d;
    logic [CntW-1:0]   stream_last;

    logic                busy_d, done_d, w_rd_en_d;
    logic [WAddrW-1:0]   w_rd_addr_d;
    logic [N-1:0]        w_valid_d, x_valid_d, y_valid_d;
    logic [N*ADDR_W-1:0] x_addr_d;

    assign stream_last = CntW'(stream_len(32'(m_q), N, PE_LAT) - 1);

    // Next-state, counter and resident-weight tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        w_loaded_d = w_loaded_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    m_d   = num_rows_i;
                    cnt_d = '0;
                    if (!keep_w_i) begin
                        w_loaded_d = 1'b0;
                    end
                    if (num_rows_i == '0) begin
                        state_d = StDone;
                    end else if (keep_w_i && w_loaded_q) begin
                        state_d = StStream;
                    end else begin
                        state_d = StLoadW;
                    end
                end
            end
            StLoadW: begin
                if (cnt_q == CntW'(N - 1)) begin
                    state_d    = StStream;
                    cnt_d      = '0;
                    w_loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (cnt_q == stream_last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered without lag.
    always_comb begin
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        w_rd_en_d   = (state_d == StLoadW);
        w_valid_d   = w_rd_en_d ? '1 : '0;
        w_rd_addr_d = w_rd_en_d ? WAddrW'(N - 1 - 32'(cnt_d)) : '0;
    end

    sysray_skew #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .PE_LAT (PE_LAT)
    ) u_skew (
        .en_i      (state_d == StStream),
        .t_i       (cnt_d),
        .m_i       (m_d),
        .x_valid_o (x_valid_d),
        .x_addr_o  (x_addr_d),
        .y_valid_o (y_valid_d)
    );

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            m_q        <= '0;
            w_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            w_loaded_q <= w_loaded_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            w_rd_en_o   <= 1'b0;
            w_rd_addr_o <= '0;
            w_valid_o   <= '0;
            x_rd_en_o   <= '0;
            x_rd_addr_o <= '0;
            x_valid_o   <= '0;
            y_valid_o   <= '0;
        end else begin
            busy_o      <= busy_d;
            done_o      <= done_d;
            w_rd_en_o   <= w_rd_en_d;
            w_rd_addr_o <= w_rd_addr_d;
            w_valid_o   <= w_valid_d;
            x_rd_en_o   <= x_valid_d;
            x_rd_addr_o <= x_addr_d;
            x_valid_o   <= x_valid_d;
            y_valid_o   <= y_valid_d;
        end
    end

`ifdef SYSRAY_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating busy-cycle count, restarted by each accepted start.
    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle && start_i) begin
            perf_d = '0;
        end else if (busy_o && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_busy_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_sysray_ctrl.sv
// Self-checking bench for sysray_ctrl: timeline model plus directed literal checks.
module tb_sysray_ctrl;
    import sysray_pkg::*;

    localparam int unsigned N      = 2;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PE_LAT = 1;
    localparam int unsigned WAW    = $clog2(N);
    localparam int unsigned VW     = 3 + WAW + 4 * N + N * ADDR_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start_i = 1'b0;
    logic                keep_w_i = 1'b0;
    logic [ADDR_W-1:0]   num_rows_i = '0;
    logic                busy_o, done_o, w_rd_en_o;
    logic [WAW-1:0]      w_rd_addr_o;
    logic [N-1:0]        w_valid_o, x_rd_en_o, x_valid_o, y_valid_o;
    logic [N*ADDR_W-1:0] x_rd_addr_o;
`ifdef SYSRAY_CTRL_PERF_EN
    logic [31:0]         perf_o;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sysray_ctrl #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .keep_w_i    (keep_w_i),
        .num_rows_i  (num_rows_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .w_rd_en_o   (w_rd_en_o),
        .w_rd_addr_o (w_rd_addr_o),
        .w_valid_o   (w_valid_o),
        .x_rd_en_o   (x_rd_en_o),
        .x_rd_addr_o (x_rd_addr_o),
        .x_valid_o   (x_valid_o),
        .y_valid_o   (y_valid_o)
`ifdef SYSRAY_CTRL_PERF_EN
        ,
        .perf_busy_cycles_o (perf_o)
`endif
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {busy_o, done_o, w_rd_en_o, w_rd_addr_o, w_valid_o, x_rd_en_o,
                      x_rd_addr_o, x_valid_o, y_valid_o};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          in_tile = 1'b0;
    int          k = 0;
    int          tile_m = 0;
    bit          tile_load = 1'b0;
    int          total = 0;
    bit          w_loaded = 1'b0;
    logic [31:0] m_perf = '0;

    // A tile is a fixed timeline of k = 1..total cycles after acceptance.
    always @(posedge clk) begin : model
        int nm;
        bit ld;
        if (rst) begin
            in_tile  <= 1'b0;
            k        <= 0;
            w_loaded <= 1'b0;
            m_perf   <= '0;
        end else begin
            if (!in_tile && start_i) m_perf <= '0;
            else if (in_tile && m_perf != 32'hffff_ffff) m_perf <= m_perf + 32'd1;
            if (in_tile) begin
                if (k == total) in_tile <= 1'b0;
                else k <= k + 1;
            end else if (start_i) begin
                nm = int'(num_rows_i);
                ld = (nm != 0) && !(keep_w_i && w_loaded);
                tile_m    <= nm;
                tile_load <= ld;
                total     <= (nm == 0) ? 1 : (ld ? N : 0) + int'(stream_len(nm, N, PE_LAT)) + 1;
                if (ld) w_loaded <= 1'b1;
                else if (!keep_w_i) w_loaded <= 1'b0;
                in_tile <= 1'b1;
                k       <= 1;
            end
        end
    end

    // Every cycle: expected outputs from the tile timeline versus the DUT.
    always @(negedge clk) begin : compare
        logic                e_busy, e_done, e_wen;
        logic [WAW-1:0]      e_waddr;
        logic [N-1:0]        e_wvalid, e_xvalid, e_yvalid;
        logic [N*ADDR_W-1:0] e_xaddr;
        int                  ofs, t, r;
        e_busy = 0; e_done = 0; e_wen = 0; e_waddr = '0; e_wvalid = '0;
        e_xvalid = '0; e_yvalid = '0; e_xaddr = '0;
        if (in_tile) begin
            e_busy = 1'b1;
            e_done = (k == total);
            ofs = tile_load ? N : 0;
            if (tile_m != 0) begin
                if (tile_load && k <= N) begin
                    e_wen    = 1'b1;
                    e_waddr  = WAW'(N - k);
                    e_wvalid = '1;
                end
                if (k > ofs && k <= ofs + int'(stream_len(tile_m, N, PE_LAT))) begin
                    t = k - 1 - ofs;
                    for (int i = 0; i < N; i++) begin
                        r = t - i;
                        if (r >= 0 && r < tile_m) begin
                            e_xvalid[i] = 1'b1;
                            e_xaddr[i*ADDR_W +: ADDR_W] = ADDR_W'(r);
                        end
                        r = t - i - (N - 1 + PE_LAT);
                        if (r >= 0 && r < tile_m) e_yvalid[i] = 1'b1;
                    end
                end
            end
        end
        if (cmp_en) begin
            chk("outputs", 64'(dut_vec), 64'({e_busy, e_done, e_wen, e_waddr, e_wvalid,
                                              e_xvalid, e_xaddr, e_xvalid, e_yvalid}));
`ifdef SYSRAY_CTRL_PERF_EN
            chk("perf", 64'(perf_o), 64'(m_perf));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    logic [WAW-1:0]    log_waddr [0:511];
    logic [N-1:0]      log_wvalid[0:511];
    logic [N-1:0]      log_xvalid[0:511];
    logic [N-1:0]      log_yvalid[0:511];
    logic [ADDR_W-1:0] log_xaddr1[0:511];

    task automatic run_tile(input int unsigned m, input bit keep, output int busy_n,
                            output int done_at, output bit saw_w, output bit saw_any);
        int cyc = 0;
        @(negedge clk); #1;
        start_i = 1'b1; keep_w_i = keep; num_rows_i = ADDR_W'(m);
        busy_n = 0; done_at = 0; saw_w = 0; saw_any = 0;
        do begin
            @(negedge clk);
            cyc++;
            log_waddr[cyc]  = w_rd_addr_o;
            log_wvalid[cyc] = w_valid_o;
            log_xvalid[cyc] = x_valid_o;
            log_yvalid[cyc] = y_valid_o;
            log_xaddr1[cyc] = x_rd_addr_o[ADDR_W +: ADDR_W];
            if (busy_o) busy_n++;
            if (done_o && done_at == 0) done_at = cyc;
            saw_w   = saw_w | w_rd_en_o;
            saw_any = saw_any | (|{w_rd_en_o, w_valid_o, x_rd_en_o, x_valid_o, y_valid_o});
            #1 start_i = 1'b0;
        end while ((busy_o || cyc == 1) && cyc < 400);
        chk("tile_terminates", 64'(busy_o), 64'(0));
    endtask

    initial begin : driver
        int  bn, da;
        bit  sw, sa, saw_done;
        logic [11:0] busy_seq;
        int  dones;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_outputs", 64'(dut_vec), 64'(0));
        #1 rst = 1'b0;

        // Tile 1: M=3, fresh weights.
        run_tile(3, 1'b0, bn, da, sw, sa);
        chk("t1_waddr_c1", 64'(log_waddr[1]), 64'(1));
        chk("t1_wvalid_c1", 64'(log_wvalid[1]), 64'(2'b11));
        chk("t1_waddr_c2", 64'(log_waddr[2]), 64'(0));
        chk("t1_wvalid_c2", 64'(log_wvalid[2]), 64'(2'b11));
        chk("t1_xvalid_seq", 64'({log_xvalid[3], log_xvalid[4], log_xvalid[5], log_xvalid[6],
                                  log_xvalid[7]}), 64'(10'b01_11_11_10_00));
        chk("t1_xaddr1_seq", 64'({log_xaddr1[4], log_xaddr1[5], log_xaddr1[6]}),
            64'({8'd0, 8'd1, 8'd2}));
        chk("t1_yvalid_seq", 64'({log_yvalid[3], log_yvalid[4], log_yvalid[5], log_yvalid[6],
                                  log_yvalid[7], log_yvalid[8]}), 64'(12'b00_00_01_11_11_10));
        chk("t1_busy", 64'(bn), 64'(9));
        chk("t1_done_at", 64'(da), 64'(9));
`ifdef SYSRAY_CTRL_PERF_EN
        chk("t1_perf", 64'(perf_o), 64'(9));
`endif

        // Tile 2: same tile, weights kept.
        run_tile(3, 1'b1, bn, da, sw, sa);
        chk("t2_busy", 64'(bn), 64'(7));
        chk("t2_done_at", 64'(da), 64'(7));
        chk("t2_no_wload", 64'(sw), 64'(0));

        // First start after reset with keep=1 still loads.
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        run_tile(3, 1'b1, bn, da, sw, sa);
        chk("t3_wload", 64'(sw), 64'(1));
        chk("t3_busy", 64'(bn), 64'(9));

        // M=0: only DONE.
        run_tile(0, 1'b0, bn, da, sw, sa);
        chk("m0_busy", 64'(bn), 64'(1));
        chk("m0_done_at", 64'(da), 64'(1));
        chk("m0_no_activity", 64'(sa), 64'(0));

        // Async reset at t=2 of STREAM.
        @(negedge clk); #1;
        start_i = 1'b1; keep_w_i = 1'b0; num_rows_i = 8'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) #1 start_i = 1'b0;
        end
        chk("pre_rst_xaddr1", 64'(x_rd_addr_o[ADDR_W +: ADDR_W]), 64'(1));
        chk("pre_rst_xvalid", 64'(x_valid_o), 64'(2'b11));
        #1 rst = 1'b1;
        #1 chk("async_rst_outputs", 64'(dut_vec), 64'(0));
        @(negedge clk); #1 rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            saw_done = saw_done | done_o;
        end
        chk("no_done_after_rst", 64'(saw_done), 64'(0));
        run_tile(2, 1'b1, bn, da, sw, sa);
        chk("post_rst_wload", 64'(sw), 64'(1));
        chk("post_rst_busy", 64'(bn), 64'(8));

        // start_i held high: one tile, idle cycle, then the next tile.
        @(negedge clk); #1;
        start_i = 1'b1; keep_w_i = 1'b0; num_rows_i = 8'd2;
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            busy_seq[12-c] = busy_o;
            if (c <= 9 && done_o) dones++;
        end
        #1 start_i = 1'b0;
        chk("held_busy_seq", 64'(busy_seq), 64'(12'b1111_1111_0111));
        chk("held_one_done", 64'(dones), 64'(1));
        for (int c = 0; c < 400 && busy_o; c++) @(negedge clk);
        chk("held_second_ends", 64'(busy_o), 64'(0));

        // Random stimulus, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            rst      = ($urandom_range(0, 499) == 0);
            start_i  = ($urandom_range(0, 3) == 0);
            keep_w_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) num_rows_i = '0;
            else if ($urandom_range(0, 7) == 0) num_rows_i = ADDR_W'($urandom_range(1, 40));
            else num_rows_i = ADDR_W'($urandom_range(1, 5));
        end
        @(negedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        repeat (60) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysray_ctrl.md
Name: sysray_ctrl

Overview:
- Sequencer for the N×N weight-stationary systolic array (sysray) and its PEs.
- On start_i it runs two phases:
  - Weight load: drives the array's weight-valid edge for N cycles.
  - Stream: drives the skewed input-valid edge and buffer read addresses for num_rows_i input vectors, then flags the skewed psum outputs at the array bottom.
- Sits between the tile buffers (weight/input SRAM read ports) and sysray; pulses done_o when the last result has left the array.

Parameters:
- N, 2, array dimension (rows = columns).
- ADDR_W, 8, input-buffer address width; at most 2^ADDR_W rows per tile.
- PE_LAT, 1, cycles from a PE's psum input to its psum output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a tile; sampled only in IDLE.
- keep_w_i  in  1  sampled with start_i; 1 = skip LOAD_W and reuse resident weights.
- num_rows_i  in  ADDR_W  M, the input vectors in the tile; captured at start.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at the end of the tile.
- w_rd_en_o  out  1  weight-buffer read enable.
- w_rd_addr_o  out  $clog2(N)  weight row to read.
- w_valid_o  out  N  to sysray in_valid_weight (one bit per column).
- x_rd_en_o  out  N  per-row input-buffer read enable.
- x_rd_addr_o  out  N×ADDR_W  per-row input-buffer address.
- x_valid_o  out  N  to sysray in_valid_input (one bit per row).
- y_valid_o  out  N  per-column result valid at the array bottom.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Async rst mid-tile aborts immediately; no done_o is produced.
- All outputs are registered.
- FSM states and transitions:
  - IDLE → LOAD_W on start_i with keep_w_i=0 and M≠0.
  - IDLE → STREAM on start_i with keep_w_i=1, M≠0 and w_loaded=1.
  - keep_w_i=1 with w_loaded=0 is treated as keep_w_i=0.
  - IDLE → DONE on start_i with M=0 (no reads, no valids).
  - LOAD_W → STREAM after N cycles.
  - STREAM → DONE after M+2N−2+PE_LAT cycles.
  - DONE → IDLE after one cycle; done_o=1 only in DONE.
- The first active output cycle is the cycle after start_i is sampled.
- start_i outside IDLE is ignored (no queueing).
- LOAD_W, counter c = 0..N−1:
  - w_rd_en_o=1, w_rd_addr_o=N−1−c (bottom row first), w_valid_o all ones.
  - w_loaded is set at the end of LOAD_W.
  - w_loaded is cleared by rst, and by any start_i with keep_w_i=0 at the moment that start_i is sampled.
- STREAM, counter t from 0 (width ADDR_W+2, no wrap for legal M):
  - x_valid_o[i] = x_rd_en_o[i] = (i ≤ t < M+i).
  - x_rd_addr_o[i] = t−i when valid, else 0.
  - y_valid_o[j] = (N−1+PE_LAT+j ≤ t < M+N−1+PE_LAT+j), i.e. row k of column j is valid at t = k+j+N−1+PE_LAT.
  - w_valid_o = 0 throughout.
- All comparisons are unsigned; t−i is never formed when t<i.

Optional Feature:
- Macro SYSRAY_CTRL_PERF_EN.
- Defined:
  - Adds output perf_busy_cycles_o, 32 bits.
  - Counts cycles with busy_o=1 and saturates at all ones.
  - Cleared by rst and on each accepted start_i.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package sysray_pkg:
  - State enum, encoded IDLE / LOAD_W / STREAM / DONE.
  - Shared default N.
  - Helper function stream_len(M,N,PE_LAT) = M+2N−2+PE_LAT, reused by the bench.
- One sub-module, sysray_skew: combinational generator of x_valid, x_addr and y_valid from t and M. It is parameterised by N, ADDR_W and PE_LAT and is instanced once.

Test Plan:
- N=2, PE_LAT=1, M=3, keep_w_i=0, start at cycle 0 →
  - cycles 1–2: w_rd_addr_o = 1, 0 with w_valid_o=11.
  - t=0..2: x_valid_o[0]=1.
  - t=1..3: x_valid_o[1]=1, x_rd_addr_o[1] = 0, 1, 2.
  - y_valid_o[0] at t=2..4, y_valid_o[1] at t=3..5.
  - done_o one cycle after t=5; busy_o for 9 cycles.
- Same tile repeated with keep_w_i=1 → no LOAD_W; STREAM starts the cycle after start; done_o after 7 cycles of busy_o.
- First start after reset with keep_w_i=1 → full LOAD_W executes (w_loaded=0).
- M=0 → busy_o for exactly 1 cycle (DONE) with done_o=1; no reads or valids.
- rst asserted at t=2 of STREAM → all outputs 0 the same cycle (async); no done_o; next start with keep_w_i=1 performs LOAD_W.
- start_i held high through a tile → exactly one tile runs, followed by a second tile starting the cycle after DONE returns to IDLE.
- With SYSRAY_CTRL_PERF_EN: M=3 tile → perf_busy_cycles_o = 9.
